// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals between two requesters,
// the arbiter and the external ALU.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [OPCODE_LENGTH-1:0] req0_op;
  logic [DATA_WIDTH-1:0]    req0_a;
  logic [DATA_WIDTH-1:0]    req0_b;
  logic                     req1_valid;
  logic                     req1_ready;
  logic [OPCODE_LENGTH-1:0] req1_op;
  logic [DATA_WIDTH-1:0]    req1_a;
  logic [DATA_WIDTH-1:0]    req1_b;
  logic                     rsp0_valid;
  logic                     rsp0_ready;
  logic                     rsp1_valid;
  logic                     rsp1_ready;
  logic [DATA_WIDTH-1:0]    rsp_result;
  logic [DATA_WIDTH-1:0]    alu_srca;
  logic [DATA_WIDTH-1:0]    alu_srcb;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]    alu_result;
  logic                     busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, alu_srca, alu_srcb, alu_op, busy
  );

  // Requester / ALU side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, alu_srca, alu_srcb, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// One operation in flight at a time: IDLE (accept) -> EXEC (ALU evaluates the
// latched operands) -> RESP (result held until the granted requester takes it).
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q,      state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     grant_q,      grant_d;
  logic [OPCODE_LENGTH-1:0] op_q,         op_d;
  logic [DATA_WIDTH-1:0]    a_q,          a_d;
  logic [DATA_WIDTH-1:0]    b_q,          b_d;
  logic [DATA_WIDTH-1:0]    result_q,     result_d;
  logic                     rsp0_valid_q, rsp0_valid_d;
  logic                     rsp1_valid_q, rsp1_valid_d;
  logic                     busy_q,       busy_d;

  logic arb_pick_s;
  logic req0_ready_s;
  logic req1_ready_s;
  logic rsp_done_s;

  // Round-robin pick: on a tie the requester not served last wins
  always_comb begin
    arb_pick_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      arb_pick_s = ~last_grant_q;
    end else if (bus.req1_valid) begin
      arb_pick_s = 1'b1;
    end else begin
      arb_pick_s = 1'b0;
    end
  end

  // Ready is combinational and only offered in IDLE to the picked requester;
  // only the granted requester's response-ready can complete a response
  always_comb begin
    req0_ready_s = (state_q == IDLE) && bus.req0_valid && !arb_pick_s;
    req1_ready_s = (state_q == IDLE) && bus.req1_valid &&  arb_pick_s;
    rsp_done_s   = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  // Next-state and datapath capture; registered outputs follow the next state
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (req0_ready_s || req1_ready_s) begin
          grant_d      = arb_pick_s;
          last_grant_d = arb_pick_s;
          op_d         = arb_pick_s ? bus.req1_op : bus.req0_op;
          a_d          = arb_pick_s ? bus.req1_a  : bus.req0_a;
          b_d          = arb_pick_s ? bus.req1_b  : bus.req0_b;
          state_d      = EXEC;
        end else begin
          state_d      = IDLE;
        end
      end
      EXEC: begin
        result_d = bus.alu_result;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d       = (state_d != IDLE);
    rsp0_valid_d = (state_d == RESP) && !grant_d;
    rsp1_valid_d = (state_d == RESP) &&  grant_d;
  end

  // State and datapath registers; async reset aborts any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req0_ready = req0_ready_s;
  assign bus.req1_ready = req1_ready_s;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_result = result_q;
  assign bus.alu_srca   = a_q;
  assign bus.alu_srcb   = b_q;
  assign bus.alu_op     = op_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepts push the hand-computed result,
// a response monitor pops and compares on every completed response.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_EQ  = 4'b1000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  bus.alu_result = bus.alu_srca + bus.alu_srcb;
      OP_SUB:  bus.alu_result = bus.alu_srca - bus.alu_srcb;
      OP_XOR:  bus.alu_result = bus.alu_srca ^ bus.alu_srcb;
      OP_EQ:   bus.alu_result = (bus.alu_srca == bus.alu_srcb) ? 32'd1 : 32'd0;
      default: bus.alu_result = 32'd0;
    endcase
  end

  typedef struct {
    int          port;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp0 = 32'd0;
  logic [31:0] exp1 = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_val = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accept monitor: one ready at most, push expectation on each handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.req0_valid || bus.req1_valid)
        check("ready_exclusive", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
      if (bus.req0_valid && bus.req0_ready) sb.push_back('{port: 0, res: exp0});
      if (bus.req1_valid && bus.req1_ready) sb.push_back('{port: 1, res: exp1});
    end
  end

  // Response monitor: exclusivity, hold stability, scoreboard compare
  always @(negedge clk) begin : rsp_mon
    exp_t e;
    logic done;
    if (reset) begin
      hold_v <= 1'b0;
    end else if (bus.rsp0_valid || bus.rsp1_valid) begin
      check("rsp_exclusive", {31'd0, bus.rsp0_valid & bus.rsp1_valid}, 32'd0);
      if (hold_v) check("rsp_hold_stable", bus.rsp_result, hold_val);
      done = (bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready);
      if (done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got port %0d result %h, required no response",
                   bus.rsp1_valid ? 1 : 0, bus.rsp_result);
        end else begin
          e = sb.pop_front();
          check("rsp_port", {31'd0, bus.rsp1_valid}, e.port);
          check("rsp_result", bus.rsp_result, e.res);
        end
        hold_v <= 1'b0;
      end else begin
        hold_v   <= 1'b1;
        hold_val <= bus.rsp_result;
      end
    end else begin
      hold_v <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; exp0 = exp;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; exp1 = exp;
    end
  endtask

  // Wait (bounded) for the handshake, return just after the accept edge
  task automatic wait_accept(input int port, input bit keep);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (port == 0) got = bus.req0_valid && bus.req0_ready;
      else           got = bus.req1_valid && bus.req1_ready;
    end
    step();
    check(port == 0 ? "accept_seen_p0" : "accept_seen_p1", {31'd0, got}, 32'd1);
    if (!keep) begin
      if (port == 0) bus.req0_valid = 1'b0;
      else           bus.req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.busy && (sb.size() == 0);
    end
    step();
    check("idle_reached", {31'd0, idle}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_op = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    check("rst_busy",     {31'd0, bus.busy},       32'd0);
    check("rst_alu_op",   {28'd0, bus.alu_op},     32'd0);
    check("rst_alu_srca", bus.alu_srca,            32'd0);
    check("rst_alu_srcb", bus.alu_srcb,            32'd0);
    check("rst_result",   bus.rsp_result,          32'd0);
    check("rst_rsp0_v",   {31'd0, bus.rsp0_valid}, 32'd0);
    check("rst_rsp1_v",   {31'd0, bus.rsp1_valid}, 32'd0);
    step();
    reset = 1'b0;

    // Single ADD on port 0, cycle-by-cycle latency
    bus.rsp0_ready = 1'b1;
    drive(0, OP_ADD, 32'd5, 32'd7, 32'd12);
    @(negedge clk);
    check("c0_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("c1_busy",     {31'd0, bus.busy},       32'd1);
    check("c1_rsp0_v",   {31'd0, bus.rsp0_valid}, 32'd0);
    check("c1_alu_op",   {28'd0, bus.alu_op},     32'd4);
    check("c1_alu_srca", bus.alu_srca,            32'd5);
    check("c1_alu_srcb", bus.alu_srcb,            32'd7);
    step();
    @(negedge clk);
    check("c2_rsp0_v",   {31'd0, bus.rsp0_valid}, 32'd1);
    check("c2_rsp1_v",   {31'd0, bus.rsp1_valid}, 32'd0);
    check("c2_result",   bus.rsp_result,          32'd12);
    step();
    @(negedge clk);
    check("c3_busy",     {31'd0, bus.busy},       32'd0);
    check("c3_rsp0_v",   {31'd0, bus.rsp0_valid}, 32'd0);
    step();

    // Tie after reset: port 0 first, then port 1
    do_reset();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive(0, OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
    drive(1, OP_XOR, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F);
    wait_accept(0, 1'b0);
    wait_accept(1, 1'b0);
    wait_idle();

    // Port 1 response held while its ready is low; port 0 ready ignored
    bus.rsp1_ready = 1'b0;
    drive(1, OP_EQ, 32'd9, 32'd9, 32'd1);
    wait_accept(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("hold_rsp1_v",  {31'd0, bus.rsp1_valid}, 32'd1);
      check("hold_rsp0_v",  {31'd0, bus.rsp0_valid}, 32'd0);
      check("hold_result",  bus.rsp_result,          32'd1);
    end
    step();
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    check("ready_rsp1_v", {31'd0, bus.rsp1_valid}, 32'd1);
    step();
    @(negedge clk);
    check("drop_rsp1_v",  {31'd0, bus.rsp1_valid}, 32'd0);
    step();

    // Port 0 held valid, port 1 once: grants 0,1,0
    drive(0, OP_ADD, 32'd10, 32'd20, 32'd30);
    drive(1, OP_SUB, 32'd100, 32'd1, 32'd99);
    wait_accept(0, 1'b1);
    drive(0, OP_XOR, 32'h0000_00AA, 32'h0000_0055, 32'h0000_00FF);
    wait_accept(1, 1'b0);
    wait_accept(0, 1'b0);
    wait_idle();

    // Reset during EXEC aborts the operation
    drive(0, OP_ADD, 32'd100, 32'd23, 32'd123);
    wait_accept(0, 1'b0);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_busy",   {31'd0, bus.busy},       32'd0);
    check("abort_alu_op", {28'd0, bus.alu_op},     32'd0);
    check("abort_srca",   bus.alu_srca,            32'd0);
    check("abort_result", bus.rsp_result,          32'd0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
      step();
    end

    // Request inputs toggled while an operation is in flight
    bus.rsp1_ready = 1'b0;
    drive(1, OP_ADD, 32'h0000_1234, 32'h0000_0001, 32'h0000_1235);
    wait_accept(1, 1'b0);
    drive(0, OP_SUB, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000);
    bus.req1_op = OP_XOR; bus.req1_a = 32'h0000_DEAD; bus.req1_b = 32'h0000_0001;
    @(negedge clk);
    check("flight_alu_op", {28'd0, bus.alu_op}, {28'd0, OP_ADD});
    check("flight_srca",   bus.alu_srca,        32'h0000_1234);
    check("flight_srcb",   bus.alu_srcb,        32'h0000_0001);
    step();
    bus.req1_op = OP_SUB; bus.req1_a = 32'h5555_5555; bus.req1_b = 32'hAAAA_AAAA;
    @(negedge clk);
    check("flight_alu_op2", {28'd0, bus.alu_op},     {28'd0, OP_ADD});
    check("flight_srca2",   bus.alu_srca,            32'h0000_1234);
    check("flight_result",  bus.rsp_result,          32'h0000_1235);
    check("flight_no_acc",  {31'd0, bus.req0_ready}, 32'd0);
    step();
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    check("resp_done_no_acc", {31'd0, bus.req0_ready}, 32'd0);
    check("resp_done_result", bus.rsp_result,          32'h0000_1235);
    wait_accept(0, 1'b0);
    wait_idle();

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of operands and result.
REQ-002 Parameter OPCODE_LENGTH, default 4, width of the ALU operation code.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready / req1_ready  output  1  requester N operation accepted this cycle.
REQ-007 req0_op / req1_op  input  OPCODE_LENGTH  ALU operation code for requester N.
REQ-008 req0_a, req0_b / req1_a, req1_b  input  DATA_WIDTH  operands SrcA, SrcB for requester N.
REQ-009 rsp0_valid / rsp1_valid  output  1  result for requester N available.
REQ-010 rsp0_ready / rsp1_ready  input  1  requester N consumes the result.
REQ-011 rsp_result  output  DATA_WIDTH  registered result, shared by both response ports.
REQ-012 alu_srca, alu_srcb  output  DATA_WIDTH  operands driven to the shared ALU.
REQ-013 alu_op  output  OPCODE_LENGTH  operation driven to the shared ALU.
REQ-014 alu_result  input  DATA_WIDTH  combinational result returned by the shared ALU.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; exactly one active at any time.
REQ-017 IDLE: reqN_ready = (state==IDLE) && reqN_valid && grant==N; combinational, at most one ready high.
REQ-018 Arbitration in IDLE: single valid requester wins; both valid -> requester other than last_grant wins (round-robin).
REQ-019 Handshake (valid && ready) latches op, a, b and grant into internal registers, updates last_grant, moves IDLE->EXEC.
REQ-020 No valid requester in IDLE: stay IDLE, no register changes.
REQ-021 alu_srca, alu_srcb, alu_op are driven solely from the latched registers, never directly from request inputs.
REQ-022 EXEC: one cycle; at its end alu_result is captured into rsp_result; EXEC->RESP unconditionally.
REQ-023 RESP: rspN_valid high only for the granted requester; the other rsp valid stays low.
REQ-024 RESP with rspN_ready high: response completes; RESP->IDLE next edge; no new accept in the same cycle.
REQ-025 RESP with rspN_ready low: hold rsp valid and rsp_result stable indefinitely.
REQ-026 rspN_ready of the non-granted requester is ignored in all states.
REQ-027 Request inputs change while not in IDLE: no effect on the in-flight operation.
REQ-028 Latency: rsp valid asserts exactly 2 cycles after the accept edge; minimum 3 cycles between accepts.
REQ-029 No arithmetic in this block; alu_result passed through at full DATA_WIDTH, no truncation or extension.

Reset
REQ-030 reset high asynchronously forces state IDLE, last_grant=1 (requester 0 wins the first tie).
REQ-031 Reset values: rsp_result=0, latched op/a/b=0 (so alu_op=0, alu_srca=0, alu_srcb=0), rsp0_valid=rsp1_valid=0, busy=0.
REQ-032 Reset during EXEC or RESP aborts the operation; no response is ever produced for it.
REQ-033 After reset release, first accept possible on the first edge where a req valid is seen in IDLE.

Verification
REQ-034 Port0 op=4'b0100, a=5, b=7, rsp0_ready=1 -> req0_ready in cycle 0, rsp0_valid cycle 2, rsp_result=12, busy low cycle 3.
REQ-035 Both valid after reset: port0 SUB a=3 b=5, port1 XOR a=0xF0 b=0xFF -> port0 served first (0xFFFFFFFE), then port1 (0x0000000F).
REQ-036 Port1 op=4'b1000 a=9 b=9 with rsp1_ready low 3 cycles -> rsp1_valid and rsp_result=1 held 3 cycles, drop cycle after ready.
REQ-037 Port0 held valid continuously, port1 valid once -> grants alternate 0,1,0; port0 never starved beyond one operation.
REQ-038 Reset asserted during EXEC of port0 ADD -> state IDLE, rsp0_valid never rises, alu_op=0, rsp_result=0.
REQ-039 Request inputs toggled during EXEC/RESP -> alu_srca/alu_srcb/alu_op and rsp_result unchanged.
